// File: rtl/nvram_upload_responder_if.sv
// Bus bundle between the HPS ioctl upload path, the game RAM arbiter and
// nvram_upload_responder.
//   ioctl_upload/index/rd/addr : HPS read request side (into the responder)
//   ioctl_din/wait             : read data and stall back to hps_io
//   mem_req/addr               : request to the shared RAM arbiter
//   mem_gnt/q                  : arbiter grant and RAM read data
// The master modport is the environment (HPS + arbiter); the slave modport is
// the responder.
interface nvram_upload_responder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [7:0]        mem_q;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_gnt, mem_q,
        input  ioctl_din, ioctl_wait, mem_req, mem_addr
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_gnt, mem_q,
        output ioctl_din, ioctl_wait, mem_req, mem_addr
    );
endinterface

// File: rtl/nvram_upload_responder.sv
// Serves HPS ioctl upload (read-back) requests for one ioctl_index, fetching
// each byte from game RAM through a request/grant port shared with the CPU and
// stalling the HPS with ioctl_wait until the byte is on ioctl_din.
//   clk_sys : system clock
//   reset   : synchronous, active-high
//   bus     : ioctl + RAM arbiter signals (slave side)
//   busy    : high whenever the FSM is not idle
//   done    : one-cycle pulse after an upload that served at least one byte ends
module nvram_upload_responder #(
    parameter logic [7:0]  INDEX  = 8'd4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned SIZE   = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    nvram_upload_responder_if.slave bus,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, REQ, LAT, CAP} state_t;

    localparam logic [24:0] SIZE_W   = 25'(SIZE);
    localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              served_q, served_d;
    logic              sel_prev_q;
    logic              sel;

    assign sel = bus.ioctl_upload && (bus.ioctl_index == INDEX);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        req_d    = req_q;
        served_d = served_q;
        done_d   = 1'b0;

        // End of upload: report whether anything was served, then forget it.
        if (sel_prev_q && !sel) begin
            done_d   = served_q;
            served_d = 1'b0;
        end

        // Losing sel aborts any read in flight; din keeps its old value.
        if (!sel) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wait_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ioctl_rd) begin
                        if (bus.ioctl_addr < SIZE_W) begin
                            addr_d  = bus.ioctl_addr[ADDR_W-1:0];
                            req_d   = 1'b1;
                            wait_d  = 1'b1;
                            state_d = REQ;
                        end else begin
                            din_d = 8'hFF;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        req_d   = 1'b0;
                        cnt_d   = LAT_INIT;
                        state_d = (RD_LAT > 1) ? LAT : CAP;
                    end
                end
                LAT: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = CAP;
                    end
                end
                CAP: begin
                    din_d    = bus.mem_q;
                    wait_d   = 1'b0;
                    served_d = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            served_q   <= 1'b0;
            sel_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            served_q   <= served_d;
            sel_prev_q <= sel;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_nvram_upload_responder.sv
// Bench for nvram_upload_responder: two instances (RD_LAT=1 and RD_LAT=3)
// share the HPS stimulus; each has its own arbiter/RAM responder.
module tb_nvram_upload_responder;
    localparam int unsigned SIZE = 1024;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        reset;
    logic        upload;
    logic        rd;
    logic [7:0]  index;
    logic [24:0] addr;

    logic [1:0]  gnt;
    logic [7:0]  q [2];
    logic [1:0]  req_w, wait_w, busy_w, done_w;
    logic [7:0]  din_w [2];
    logic [9:0]  maddr_w [2];

    logic [7:0]  ram [SIZE];
    int          dly [2];
    int          wcnt [2];
    int          dcnt [2];
    logic [9:0]  gaddr [2];
    logic [9:0]  hold [2];
    bit          req_seen [2];

    logic [7:0]  exp_din;
    bit          served;
    int          total;
    int          bad;

    nvram_upload_responder_if #(.ADDR_W(10)) bus_a ();
    nvram_upload_responder_if #(.ADDR_W(10)) bus_b ();

    assign bus_a.ioctl_upload = upload;
    assign bus_a.ioctl_index  = index;
    assign bus_a.ioctl_rd     = rd;
    assign bus_a.ioctl_addr   = addr;
    assign bus_a.mem_gnt      = gnt[0];
    assign bus_a.mem_q        = q[0];
    assign bus_b.ioctl_upload = upload;
    assign bus_b.ioctl_index  = index;
    assign bus_b.ioctl_rd     = rd;
    assign bus_b.ioctl_addr   = addr;
    assign bus_b.mem_gnt      = gnt[1];
    assign bus_b.mem_q        = q[1];

    assign req_w      = {bus_b.mem_req, bus_a.mem_req};
    assign wait_w     = {bus_b.ioctl_wait, bus_a.ioctl_wait};
    assign din_w[0]   = bus_a.ioctl_din;
    assign din_w[1]   = bus_b.ioctl_din;
    assign maddr_w[0] = bus_a.mem_addr;
    assign maddr_w[1] = bus_b.mem_addr;

    nvram_upload_responder #(.INDEX(8'd4), .ADDR_W(10), .SIZE(SIZE), .RD_LAT(LAT0)) dut_a (
        .clk_sys(clk), .reset(reset), .bus(bus_a), .busy(busy_w[0]), .done(done_w[0])
    );
    nvram_upload_responder #(.INDEX(8'd4), .ADDR_W(10), .SIZE(SIZE), .RD_LAT(LAT1)) dut_b (
        .clk_sys(clk), .reset(reset), .bus(bus_b), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter + RAM model: grants after dly[k] request cycles, returns the byte
    // exactly RD_LAT cycles after the grant cycle, random junk otherwise.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            gnt[k] = 1'b0;
            q[k]   = 8'($urandom);
            if (reset) begin
                wcnt[k] = 0;
                dcnt[k] = 0;
            end else begin
                if (dcnt[k] != 0) begin
                    dcnt[k]--;
                    if (dcnt[k] == 0) q[k] = ram[gaddr[k]];
                end
                if (req_w[k]) begin
                    req_seen[k] = 1'b1;
                    if (wcnt[k] != 0) begin
                        total++;
                        if (maddr_w[k] !== hold[k]) begin
                            bad++;
                            $display("FAIL addr_stable dut%0d: mem_addr=%h required %h", k, maddr_w[k], hold[k]);
                        end
                    end
                    hold[k] = maddr_w[k];
                    if (wcnt[k] == dly[k]) begin
                        gnt[k]   = 1'b1;
                        gaddr[k] = maddr_w[k];
                        dcnt[k]  = (k == 0) ? LAT0 : LAT1;
                        wcnt[k]  = 0;
                    end else begin
                        wcnt[k]++;
                    end
                end else begin
                    wcnt[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a);
        addr = a;
        rd   = 1'b1;
        tick();
        rd   = 1'b0;
    endtask

    // Issues one read and counts wait cycles per instance until both are idle;
    // also advances the reference model (expected din, served flag).
    task automatic do_read(input logic [24:0] a, input int d0, input int d1,
                           output int wc0, output int wc1);
        bit fin;
        dly[0] = d0;
        dly[1] = d1;
        strobe(a);
        wc0 = 0;
        wc1 = 0;
        fin = 1'b0;
        for (int n = 0; n < 64 && !fin; n++) begin
            if (wait_w == 2'b00 && busy_w == 2'b00) begin
                fin = 1'b1;
            end else begin
                if (wait_w[0]) wc0++;
                if (wait_w[1]) wc1++;
                tick();
            end
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL read_timeout addr=%h: busy=%b after 64 cycles, required 00", a, busy_w);
        end
        if (a < 25'(SIZE)) begin
            exp_din = ram[a[9:0]];
            served  = 1'b1;
        end else begin
            exp_din = 8'hFF;
        end
    endtask

    task automatic drop_upload(output int p0, output int p1, output logic f0, output logic f1);
        upload = 1'b0;
        p0 = 0;
        p1 = 0;
        tick();
        f0 = done_w[0];
        f1 = done_w[1];
        for (int n = 0; n < 4; n++) begin
            if (done_w[0]) p0++;
            if (done_w[1]) p1++;
            tick();
        end
        served = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        upload = 1'b1;
        index  = 8'd4;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({din_w[k], wait_w[k], req_w[k], maddr_w[k], busy_w[k], done_w[k]} !== 22'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d: din=%h wait=%b req=%b addr=%h busy=%b done=%b required all 0",
                         k, din_w[k], wait_w[k], req_w[k], maddr_w[k], busy_w[k], done_w[k]);
            end
        end
        upload  = 1'b0;
        reset   = 1'b0;
        exp_din = 8'h00;
        served  = 1'b0;
        tick();
    endtask

    task automatic test_wrong_index();
        int p0, p1;
        logic f0, f1;
        upload = 1'b1;
        index  = 8'd0;
        for (int i = 0; i < 4; i++) begin
            strobe(25'($urandom_range(SIZE - 1)));
            for (int c = 0; c < 5; c++) begin
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if ({req_w[k], wait_w[k], din_w[k], done_w[k]} !== 11'd0) begin
                        bad++;
                        $display("FAIL wrong_index dut%0d: req=%b wait=%b din=%h done=%b required all 0",
                                 k, req_w[k], wait_w[k], din_w[k], done_w[k]);
                    end
                end
                tick();
            end
        end
        drop_upload(p0, p1, f0, f1);
        total++;
        if (p0 != 0 || p1 != 0) begin
            bad++;
            $display("FAIL wrong_index_done: pulses=%0d/%0d required 0/0", p0, p1);
        end
        index = 8'd4;
    endtask

    task automatic test_single();
        int wc0, wc1, p0, p1;
        logic f0, f1;
        ram[5] = 8'h5A;
        upload = 1'b1;
        tick();
        do_read(25'h005, 0, 0, wc0, wc1);
        total++;
        if (wc0 != LAT0 + 1 || wc1 != LAT1 + 1) begin
            bad++;
            $display("FAIL single_wait: cycles=%0d/%0d required %0d/%0d", wc0, wc1, LAT0 + 1, LAT1 + 1);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (din_w[k] !== 8'h5A || maddr_w[k] !== 10'h005) begin
                bad++;
                $display("FAIL single_data dut%0d: din=%h addr=%h required 5a/005", k, din_w[k], maddr_w[k]);
            end
        end
        drop_upload(p0, p1, f0, f1);
        total++;
        if ({f0, f1} !== 2'b11 || p0 != 1 || p1 != 1) begin
            bad++;
            $display("FAIL single_done: first=%b%b pulses=%0d/%0d required 11 1/1", f0, f1, p0, p1);
        end
    endtask

    task automatic test_grant_delay();
        int wc0, wc1, d0, d1, p0, p1;
        logic f0, f1;
        logic [24:0] a;
        upload = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            d0 = (i == 0) ? 7 : int'($urandom_range(9));
            d1 = (i == 0) ? 7 : int'($urandom_range(9));
            a  = (i % 3 == 2) ? 25'($urandom_range(4095, SIZE)) : 25'($urandom_range(SIZE - 1));
            do_read(a, d0, d1, wc0, wc1);
            total++;
            if (a < 25'(SIZE)) begin
                if (wc0 != d0 + LAT0 + 1 || wc1 != d1 + LAT1 + 1) begin
                    bad++;
                    $display("FAIL delay_wait addr=%h: cycles=%0d/%0d required %0d/%0d",
                             a, wc0, wc1, d0 + LAT0 + 1, d1 + LAT1 + 1);
                end
            end else if (wc0 != 0 || wc1 != 0) begin
                bad++;
                $display("FAIL delay_wait addr=%h: cycles=%0d/%0d required 0/0", a, wc0, wc1);
            end
            total++;
            if (din_w[0] !== exp_din || din_w[1] !== exp_din) begin
                bad++;
                $display("FAIL delay_data addr=%h: din=%h/%h required %h", a, din_w[0], din_w[1], exp_din);
            end
        end
        drop_upload(p0, p1, f0, f1);
        total++;
        if (p0 != 1 || p1 != 1) begin
            bad++;
            $display("FAIL delay_done: pulses=%0d/%0d required 1/1", p0, p1);
        end
    endtask

    task automatic test_out_of_range();
        int wc0, wc1, p0, p1;
        logic f0, f1;
        logic [24:0] oor [4];
        oor[0] = 25'h0000400;
        oor[1] = 25'h1000400;
        oor[2] = 25'h1FFFFFF;
        oor[3] = 25'($urandom_range(32'h1FFFFFF, SIZE));
        req_seen[0] = 1'b0;
        req_seen[1] = 1'b0;
        upload = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            do_read(oor[i], 0, 0, wc0, wc1);
            total++;
            if (wc0 != 0 || wc1 != 0 || din_w[0] !== 8'hFF || din_w[1] !== 8'hFF) begin
                bad++;
                $display("FAIL oor addr=%h: wait cycles=%0d/%0d din=%h/%h required 0/0 ff/ff",
                         oor[i], wc0, wc1, din_w[0], din_w[1]);
            end
        end
        total++;
        if (req_seen[0] || req_seen[1]) begin
            bad++;
            $display("FAIL oor_req: mem_req seen=%b%b required 00", req_seen[0], req_seen[1]);
        end
        drop_upload(p0, p1, f0, f1);
        total++;
        if (p0 != 0 || p1 != 0) begin
            bad++;
            $display("FAIL oor_done: pulses=%0d/%0d required 0/0", p0, p1);
        end
    endtask

    task automatic test_abort();
        int wc0, wc1;
        logic [7:0] prev;
        upload = 1'b1;
        tick();
        do_read(25'($urandom_range(SIZE - 1)), 0, 0, wc0, wc1);
        prev   = exp_din;
        dly[0] = 100;
        dly[1] = 100;
        strobe(25'($urandom_range(SIZE - 1)));
        tick();
        tick();
        total++;
        if (req_w !== 2'b11) begin
            bad++;
            $display("FAIL abort_pre: mem_req=%b required 11", req_w);
        end
        upload = 1'b0;
        tick();
        total++;
        if (req_w !== 2'b00 || wait_w !== 2'b00 || busy_w !== 2'b00 || done_w !== 2'b11 ||
            din_w[0] !== prev || din_w[1] !== prev) begin
            bad++;
            $display("FAIL abort_req: req=%b wait=%b busy=%b done=%b din=%h/%h required 00 00 00 11 %h",
                     req_w, wait_w, busy_w, done_w, din_w[0], din_w[1], prev);
        end
        served = 1'b0;
        tick();
        // Second upload: drop during capture (lat 1) / latency wait (lat 3).
        upload = 1'b1;
        dly[0] = 0;
        dly[1] = 0;
        tick();
        strobe(25'($urandom_range(SIZE - 1)));
        tick();
        upload = 1'b0;
        tick();
        total++;
        if (req_w !== 2'b00 || wait_w !== 2'b00 || busy_w !== 2'b00 || done_w !== 2'b00 ||
            din_w[0] !== prev || din_w[1] !== prev) begin
            bad++;
            $display("FAIL abort_lat: req=%b wait=%b busy=%b done=%b din=%h/%h required 00 00 00 00 %h",
                     req_w, wait_w, busy_w, done_w, din_w[0], din_w[1], prev);
        end
        repeat (5) tick();
        total++;
        if (din_w[0] !== prev || din_w[1] !== prev || done_w !== 2'b00) begin
            bad++;
            $display("FAIL abort_late: din=%h/%h done=%b required %h 00", din_w[0], din_w[1], done_w, prev);
        end
    endtask

    task automatic test_reset_abort();
        int wc0, wc1, p0, p1;
        logic f0, f1;
        upload = 1'b1;
        tick();
        do_read(25'($urandom_range(SIZE - 1)), 1, 1, wc0, wc1);
        dly[0] = 100;
        dly[1] = 100;
        strobe(25'($urandom_range(SIZE - 1)));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_din = 8'h00;
        served  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({din_w[k], wait_w[k], req_w[k], busy_w[k], done_w[k]} !== 12'd0) begin
                bad++;
                $display("FAIL reset_abort dut%0d: din=%h wait=%b req=%b busy=%b done=%b required all 0",
                         k, din_w[k], wait_w[k], req_w[k], busy_w[k], done_w[k]);
            end
        end
        tick();
        drop_upload(p0, p1, f0, f1);
        total++;
        if (p0 != 0 || p1 != 0) begin
            bad++;
            $display("FAIL reset_abort_done: pulses=%0d/%0d required 0/0", p0, p1);
        end
    endtask

    task automatic test_dump();
        int wc0, wc1, d0, d1, p0, p1;
        logic f0, f1;
        upload = 1'b1;
        tick();
        for (int a = 0; a < int'(SIZE); a++) begin
            d0 = int'($urandom_range(5));
            d1 = int'($urandom_range(5));
            do_read(25'(a), d0, d1, wc0, wc1);
            total++;
            if (din_w[0] !== ram[a] || din_w[1] !== ram[a]) begin
                bad++;
                $display("FAIL dump_data addr=%0d: din=%h/%h required %h", a, din_w[0], din_w[1], ram[a]);
            end
            total++;
            if (wc0 != d0 + LAT0 + 1 || wc1 != d1 + LAT1 + 1) begin
                bad++;
                $display("FAIL dump_wait addr=%0d: cycles=%0d/%0d required %0d/%0d",
                         a, wc0, wc1, d0 + LAT0 + 1, d1 + LAT1 + 1);
            end
        end
        drop_upload(p0, p1, f0, f1);
        total++;
        if (p0 != 1 || p1 != 1) begin
            bad++;
            $display("FAIL dump_done: pulses=%0d/%0d required 1/1", p0, p1);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        upload = 1'b0;
        rd     = 1'b0;
        index  = 8'd4;
        addr   = '0;
        dly[0] = 0;
        dly[1] = 0;
        for (int i = 0; i < int'(SIZE); i++) ram[i] = 8'($urandom);
        tick();
        test_reset();
        test_wrong_index();
        test_single();
        test_grant_delay();
        test_out_of_range();
        test_abort();
        test_reset_abort();
        test_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
